imm_issue_ctrl: RTL and testbench
=================================

Name: imm_issue_ctrl

Overview:
- ID-stage controller that sequences the immediate-extension datapath of the 16-bit core.
- Accepts fetched instructions from IF over a valid/ready handshake and classifies each opcode into an extension type.
- Produces the extended 16-bit immediate and registers it with the instruction toward EX.
- Contains a one-entry skid buffer so EX back-pressure never drops an instruction, and supports flush on branch redirect.

Parameters:
- INST_W, 16, instruction width (matches INST_BUS)
- DATA_W, 16, data/immediate width (matches DATA_BUS)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_valid  in  1  IF presents an instruction
- if_inst  in  16  instruction from IF
- if_ready  out  1  controller can accept; equals skid-buffer empty
- flush  in  1  branch redirect; kills held and output instructions
- ex_ready  in  1  EX accepts output this cycle
- ex_valid  out  1  output register holds a live instruction
- ex_inst  out  16  registered instruction
- ex_imm  out  16  registered extended immediate
- ex_imm_type  out  3  0 none, 1 zext[7:0], 2 sext[10:0], 3 sext[7:0], 4 sext[4:0], 5 sext[3:0], 6 shamt
- ex_illegal  out  1  present only with IMM_ILLEGAL_DETECT_EN

Behaviour:
- Reset (rst=0, asynchronous): ex_valid=0, ex_inst=0, ex_imm=0, ex_imm_type=0, skid empty, if_ready=1, ex_illegal=0.
- Classification is combinational on op = inst[15:11]:
  - 01101 LI -> type 1
  - 00010 B -> type 2
  - 00100 BEQZ, 00101 BNEZ, 01001 ADDIU, 01010 SLTI, 01110 CMPI, 10010 LW_SP, 11010 SW_SP, 01100 ADDSP/BTEQZ -> type 3
  - 10011 LW, 11011 SW -> type 4
  - 01000 ADDIU3 -> type 5
  - 00110 SLL/SRA/SRL -> type 6: imm = {13'b0, inst[4:2]}, with inst[4:2]==0 giving 16'd8
  - all other opcodes -> type 0, imm = 0
- Extension arithmetic: zero-extension pads with zeros; sign-extension replicates the top kept bit (inst[10], [7], [4] or [3]) to bit 15.
- Latency: an instruction accepted at edge N appears on ex_* after edge N; one-cycle latency when not stalled.
- Output register advances when ex_valid=0 or ex_ready=1. Source priority: skid buffer first, else IF when if_valid & if_ready.
- Stall case (output stalled and IF transfers): the instruction, immediate and type are captured into the skid buffer. if_ready drops the following cycle.
- Skid full plus output stalled: if_ready=0 and all state holds.
- Simultaneous events:
  - Output drains and skid is full in the same cycle: skid moves to output, and the IF transfer is blocked that cycle because if_ready=0.
  - Skid is empty and output drains: a simultaneous IF transfer goes directly to output.
- Flush (synchronous, highest priority over all transfers):
  - Next edge: ex_valid=0, skid cleared, if_ready=1.
  - An if_valid on the flush cycle is discarded.
  - Data fields may hold stale values while ex_valid=0.
- Ordering: instructions leave strictly in acceptance order. No duplication, no loss.
- ex_* are stable whenever ex_valid=1 and ex_ready=0.

Optional Feature:
- Macro: IMM_ILLEGAL_DETECT_EN.
- Defined:
  - Opcodes outside the decoded set (excluding the no-immediate R-type groups 11100, 11101, 11110, 11111, 00001, 00000) set ex_illegal=1 alongside that instruction. The flag travels through the skid buffer.
  - ex_illegal resets to 0 and is cleared by flush.
- Undefined: the ex_illegal port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset mid-stream with ex_valid=1 -> all outputs 0 immediately (asynchronous), if_ready=1 next cycle.
- ex_ready=1, stream 0x4980 (ADDIU imm 0x80), 0x6DFF (LI), 0x17FF (B) -> ex_imm 0xFF80/type3, then 0x00FF/type1, then 0xFFFF/type2, on consecutive cycles.
- 0x9B1F (LW, imm 11111) with ex_ready=0 for 3 cycles while IF offers 0x4108 (ADDIU3, imm 1000) -> 0x4108 captured in skid, if_ready=0 next cycle, ex_imm 0xFFFF held. On release: 0xFFF8/type5 follows, no loss.
- 0x3000 (SLL, shamt 000) then 0x300C (shamt 011) -> imm 0x0008 then 0x0003, type 6.
- Skid full, output stalled, flush=1 -> next cycle ex_valid=0, if_ready=1. The next accepted instruction emerges alone.
- With IMM_ILLEGAL_DETECT_EN: 0xF800 (op 11111, R-type) gives ex_illegal=0; 0x8000 (op 10000) gives ex_illegal=1 with type 0 and imm 0x0000.

Source files
------------

// File: rtl/imm_issue_ctrl.sv
// ID-stage immediate issue controller: decodes the immediate kind, extends it and hands it to EX with a one-entry skid buffer.
// Optional ex_illegal flag when IMM_ILLEGAL_DETECT_EN is defined.
module imm_issue_ctrl #(
   parameter int INST_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_valid,
   input  logic [INST_W-1:0] if_inst,
   output logic              if_ready,
   input  logic              flush,
   input  logic              ex_ready,
   output logic              ex_valid,
   output logic [INST_W-1:0] ex_inst,
   output logic [DATA_W-1:0] ex_imm,
   output logic [2:0]        ex_imm_type
`ifdef IMM_ILLEGAL_DETECT_EN
   ,
   output logic              ex_illegal
`endif
);

   function automatic logic [2:0] imm_type_of(input logic [4:0] op);
      case (op)
         5'b01101:                                  imm_type_of = 3'd1;
         5'b00010:                                  imm_type_of = 3'd2;
         5'b00100, 5'b00101, 5'b01001, 5'b01010,
         5'b01110, 5'b10010, 5'b11010, 5'b01100:    imm_type_of = 3'd3;
         5'b10011, 5'b11011:                        imm_type_of = 3'd4;
         5'b01000:                                  imm_type_of = 3'd5;
         5'b00110:                                  imm_type_of = 3'd6;
         default:                                   imm_type_of = 3'd0;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] imm_of(input logic [2:0] ty, input logic [INST_W-1:0] inst);
      case (ty)
         3'd1:    imm_of = {{(DATA_W-8){1'b0}}, inst[7:0]};
         3'd2:    imm_of = {{(DATA_W-11){inst[10]}}, inst[10:0]};
         3'd3:    imm_of = {{(DATA_W-8){inst[7]}}, inst[7:0]};
         3'd4:    imm_of = {{(DATA_W-5){inst[4]}}, inst[4:0]};
         3'd5:    imm_of = {{(DATA_W-4){inst[3]}}, inst[3:0]};
         // A zero shift field encodes a shift by eight
         3'd6:    imm_of = (inst[4:2] == 3'd0) ? DATA_W'(8) : {{(DATA_W-3){1'b0}}, inst[4:2]};
         default: imm_of = '0;
      endcase
   endfunction

   logic [2:0]        dec_type;
   logic [DATA_W-1:0] dec_imm;
   logic              adv, fire;

   logic              ex_valid_q, ex_valid_d;
   logic [INST_W-1:0] ex_inst_q, ex_inst_d;
   logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
   logic [2:0]        ex_type_q, ex_type_d;
   logic              skid_vld_q, skid_vld_d;
   logic [INST_W-1:0] skid_inst_q, skid_inst_d;
   logic [DATA_W-1:0] skid_imm_q, skid_imm_d;
   logic [2:0]        skid_type_q, skid_type_d;

`ifdef IMM_ILLEGAL_DETECT_EN
   function automatic logic is_illegal(input logic [4:0] op);
      case (op)
         5'b11100, 5'b11101, 5'b11110, 5'b11111, 5'b00001, 5'b00000: is_illegal = 1'b0;
         default: is_illegal = (imm_type_of(op) == 3'd0);
      endcase
   endfunction

   logic dec_ill;
   logic ex_ill_q, ex_ill_d, skid_ill_q, skid_ill_d;
   assign dec_ill    = is_illegal(if_inst[15:11]);
   assign ex_illegal = ex_ill_q;
`endif

   assign dec_type = imm_type_of(if_inst[15:11]);
   assign dec_imm  = imm_of(dec_type, if_inst);

   assign if_ready    = ~skid_vld_q;
   assign adv         = ~ex_valid_q | ex_ready;
   assign fire        = if_valid & if_ready;
   assign ex_valid    = ex_valid_q;
   assign ex_inst     = ex_inst_q;
   assign ex_imm      = ex_imm_q;
   assign ex_imm_type = ex_type_q;

   always_comb begin
      ex_valid_d  = ex_valid_q;
      ex_inst_d   = ex_inst_q;
      ex_imm_d    = ex_imm_q;
      ex_type_d   = ex_type_q;
      skid_vld_d  = skid_vld_q;
      skid_inst_d = skid_inst_q;
      skid_imm_d  = skid_imm_q;
      skid_type_d = skid_type_q;
`ifdef IMM_ILLEGAL_DETECT_EN
      ex_ill_d    = ex_ill_q;
      skid_ill_d  = skid_ill_q;
`endif
      if (flush) begin
         ex_valid_d = 1'b0;
         skid_vld_d = 1'b0;
`ifdef IMM_ILLEGAL_DETECT_EN
         ex_ill_d   = 1'b0;
         skid_ill_d = 1'b0;
`endif
      end else if (adv) begin
         // The skid entry is older than anything IF offers, so it drains first
         if (skid_vld_q) begin
            ex_valid_d = 1'b1;
            ex_inst_d  = skid_inst_q;
            ex_imm_d   = skid_imm_q;
            ex_type_d  = skid_type_q;
            skid_vld_d = 1'b0;
`ifdef IMM_ILLEGAL_DETECT_EN
            ex_ill_d   = skid_ill_q;
`endif
         end else if (fire) begin
            ex_valid_d = 1'b1;
            ex_inst_d  = if_inst;
            ex_imm_d   = dec_imm;
            ex_type_d  = dec_type;
`ifdef IMM_ILLEGAL_DETECT_EN
            ex_ill_d   = dec_ill;
`endif
         end else begin
            ex_valid_d = 1'b0;
         end
      end else if (fire) begin
         skid_vld_d  = 1'b1;
         skid_inst_d = if_inst;
         skid_imm_d  = dec_imm;
         skid_type_d = dec_type;
`ifdef IMM_ILLEGAL_DETECT_EN
         skid_ill_d  = dec_ill;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_valid_q  <= 1'b0;
         ex_inst_q   <= '0;
         ex_imm_q    <= '0;
         ex_type_q   <= '0;
         skid_vld_q  <= 1'b0;
         skid_inst_q <= '0;
         skid_imm_q  <= '0;
         skid_type_q <= '0;
`ifdef IMM_ILLEGAL_DETECT_EN
         ex_ill_q    <= 1'b0;
         skid_ill_q  <= 1'b0;
`endif
      end else begin
         ex_valid_q  <= ex_valid_d;
         ex_inst_q   <= ex_inst_d;
         ex_imm_q    <= ex_imm_d;
         ex_type_q   <= ex_type_d;
         skid_vld_q  <= skid_vld_d;
         skid_inst_q <= skid_inst_d;
         skid_imm_q  <= skid_imm_d;
         skid_type_q <= skid_type_d;
`ifdef IMM_ILLEGAL_DETECT_EN
         ex_ill_q    <= ex_ill_d;
         skid_ill_q  <= skid_ill_d;
`endif
      end
   end

endmodule

// File: tb/tb_imm_issue_ctrl.sv
// Scoreboard bench for imm_issue_ctrl: accepted instructions are queued with their expected extension and
// compared against ex_* while they sit in the output register.
module tb_imm_issue_ctrl;

   typedef struct packed {
      logic [15:0] inst;
      logic [15:0] imm;
      logic [2:0]  ty;
      logic        ill;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic [15:0] if_inst;
   logic        if_ready;
   logic        flush;
   logic        ex_ready;
   logic        ex_valid;
   logic [15:0] ex_inst;
   logic [15:0] ex_imm;
   logic [2:0]  ex_imm_type;
`ifdef IMM_ILLEGAL_DETECT_EN
   logic        ex_illegal;
`endif

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   imm_issue_ctrl #(.INST_W(16), .DATA_W(16)) dut (
      .clk(clk), .rst(rst),
      .if_valid(if_valid), .if_inst(if_inst), .if_ready(if_ready),
      .flush(flush), .ex_ready(ex_ready),
      .ex_valid(ex_valid), .ex_inst(ex_inst), .ex_imm(ex_imm), .ex_imm_type(ex_imm_type)
`ifdef IMM_ILLEGAL_DETECT_EN
      , .ex_illegal(ex_illegal)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: sign extension via arithmetic right shift of a left-justified field
   function automatic exp_t model(input logic [15:0] inst);
      exp_t e;
      logic signed [15:0] t;
      logic [4:0] op;
      op = inst[15:11];
      e.inst = inst;
      e.imm = 16'h0;
      e.ty = 3'd0;
      if (op == 5'b01101) begin
         e.ty = 3'd1; e.imm = 16'(inst[7:0]);
      end else if (op == 5'b00010) begin
         e.ty = 3'd2; t = $signed({inst[10:0], 5'b0}) >>> 5; e.imm = t;
      end else if (op inside {5'b00100, 5'b00101, 5'b01001, 5'b01010, 5'b01110, 5'b10010, 5'b11010, 5'b01100}) begin
         e.ty = 3'd3; t = $signed({inst[7:0], 8'b0}) >>> 8; e.imm = t;
      end else if (op inside {5'b10011, 5'b11011}) begin
         e.ty = 3'd4; t = $signed({inst[4:0], 11'b0}) >>> 11; e.imm = t;
      end else if (op == 5'b01000) begin
         e.ty = 3'd5; t = $signed({inst[3:0], 12'b0}) >>> 12; e.imm = t;
      end else if (op == 5'b00110) begin
         e.ty = 3'd6; e.imm = (inst[4:2] == 3'b000) ? 16'd8 : 16'(inst[4:2]);
      end
      e.ill = (e.ty == 3'd0) && !(op inside {5'b11100, 5'b11101, 5'b11110, 5'b11111, 5'b00001, 5'b00000});
      return e;
   endfunction

   task automatic check_outs();
      chk("ex_valid", 32'(ex_valid), 32'(sb.size() > 0));
      chk("if_ready", 32'(if_ready), 32'(sb.size() < 2));
      if (sb.size() > 0) begin
         chk("ex_inst", 32'(ex_inst), 32'(sb[0].inst));
         chk("ex_imm", 32'(ex_imm), 32'(sb[0].imm));
         chk("ex_imm_type", 32'(ex_imm_type), 32'(sb[0].ty));
`ifdef IMM_ILLEGAL_DETECT_EN
         chk("ex_illegal", 32'(ex_illegal), 32'(sb[0].ill));
`endif
      end
   endtask

   // Drive one cycle (called at a negedge), update the scoreboard at the edge, check at the next negedge
   task automatic step(input logic v, input logic [15:0] inst, input logic er, input logic fl);
      logic acc, drn;
      exp_t e;
      if_valid = v; if_inst = inst; ex_ready = er; flush = fl;
      acc = v && (sb.size() < 2) && !fl;
      drn = (sb.size() > 0) && er && !fl;
      e = model(inst);
      @(posedge clk);
      if (fl) sb.delete();
      else begin
         if (drn) void'(sb.pop_front());
         if (acc) sb.push_back(e);
      end
      @(negedge clk);
      check_outs();
   endtask

   logic [15:0] ops [12] = '{16'h6800, 16'h1000, 16'h4800, 16'h2000, 16'h9800, 16'h4000,
                             16'h3000, 16'hF800, 16'h8000, 16'h0000, 16'hD000, 16'hB800};

   initial begin
      rst = 1'b0; if_valid = 1'b0; if_inst = 16'h0; flush = 1'b0; ex_ready = 1'b0;
      #2;
      chk("rst_ex_valid", 32'(ex_valid), 32'd0);
      chk("rst_if_ready", 32'(if_ready), 32'd1);
      chk("rst_ex_imm", 32'(ex_imm), 32'd0);
      @(negedge clk); rst = 1'b1;

      // Back-to-back stream with EX always ready
      step(1, 16'h4980, 1, 0);
      step(1, 16'h6DFF, 1, 0);
      step(1, 16'h17FF, 1, 0);
      step(0, 16'h0000, 1, 0);

      // Stall with LW in output, ADDIU3 lands in the skid buffer
      step(1, 16'h9B1F, 0, 0);
      step(1, 16'h4108, 0, 0);
      step(1, 16'h6DFF, 0, 0);
      step(1, 16'h6DFF, 0, 0);
      step(1, 16'h6DFF, 1, 0);
      step(0, 16'h0000, 1, 0);
      step(0, 16'h0000, 1, 0);

      // Shift amounts, zero field meaning eight
      step(1, 16'h3000, 1, 0);
      step(1, 16'h300C, 1, 0);
      step(0, 16'h0000, 1, 0);

      // Flush with skid full and output stalled, then a lone instruction
      step(1, 16'h9B1F, 0, 0);
      step(1, 16'h4108, 0, 0);
      step(1, 16'h6DFF, 0, 1);
      step(1, 16'h17FF, 1, 0);
      step(0, 16'h0000, 1, 0);

      // Illegal-detect opcodes and a flush with if_valid on an empty pipe
      step(1, 16'hF800, 1, 0);
      step(1, 16'h8000, 1, 0);
      step(1, 16'h4980, 1, 1);
      step(0, 16'h0000, 1, 0);

      // Randomised traffic with back-pressure and occasional flush
      for (int i = 0; i < 300; i++) begin
         logic [15:0] r;
         r = ops[$urandom_range(0, 11)] | 16'($urandom_range(0, 2047));
         step(1'($urandom_range(0, 3) != 0), r, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
      end

      // Asynchronous reset while ex_valid is high
      step(1, 16'h9B1F, 0, 0);
      step(1, 16'h4108, 0, 0);
      #2 rst = 1'b0;
      #1;
      chk("arst_ex_valid", 32'(ex_valid), 32'd0);
      chk("arst_ex_inst", 32'(ex_inst), 32'd0);
      chk("arst_ex_imm", 32'(ex_imm), 32'd0);
      chk("arst_ex_type", 32'(ex_imm_type), 32'd0);
      chk("arst_if_ready", 32'(if_ready), 32'd1);
`ifdef IMM_ILLEGAL_DETECT_EN
      chk("arst_ex_illegal", 32'(ex_illegal), 32'd0);
`endif
      sb.delete();
      @(negedge clk); rst = 1'b1;
      step(0, 16'h0000, 1, 0);
      step(1, 16'h4108, 1, 0);
      step(0, 16'h0000, 1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
